// File: rtl/periph_pkg.sv
// rtl/periph_pkg.sv - shared constants and types for the FIFO drain engine
package periph_pkg;

   localparam int DATA_W     = 32;
   localparam int SKID_DEPTH = 2;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } drain_state_t;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - 2-entry FIFO-ordered skid buffer with simultaneous push/pop
module skid_buf2 #(
   parameter int W = periph_pkg::DATA_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [W-1:0]                 push_data,
   input  logic                         pop,
   output logic [W-1:0]                 head_data,
   output logic [periph_pkg::OCC_W-1:0] occupancy
);
   import periph_pkg::*;

   logic [W-1:0] tail_q;
   logic         do_pop;

   assign do_pop = pop && (occupancy != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         head_data <= '0;
         tail_q    <= '0;
         occupancy <= '0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               // An empty buffer loads straight into the head; no bypass to the output.
               if (occupancy == '0)
                  head_data <= push_data;
               else
                  tail_q <= push_data;
               occupancy <= occupancy + OCC_W'(1);
            end
            2'b01: begin
               head_data <= tail_q;
               occupancy <= occupancy - OCC_W'(1);
            end
            2'b11: begin
               if (occupancy == OCC_W'(1)) begin
                  head_data <= push_data;
               end else begin
                  head_data <= tail_q;
                  tail_q    <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - FIFO read-side drain engine feeding a skid-buffered valid/ready stream
module fifo_drain #(
   parameter int DATA_W = periph_pkg::DATA_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CNT_W-1:0]  words_out,
   output logic              busy
);
   import periph_pkg::*;

   drain_state_t     state;
   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   occ_after;
   logic             accept;
   logic             capture;
   logic             can_issue;

   assign accept  = m_valid && m_ready;
   assign capture = (state == CAPTURE);

   // Occupancy once this edge settles, counting the word being captured now;
   // a new pop is only allowed while that leaves room for the next in-flight word.
   assign occ_after = {1'b0, occ} + {{OCC_W{1'b0}}, capture} - {{OCC_W{1'b0}}, accept};
   assign can_issue = enable && !fifo_empty && (occ_after < (OCC_W+1)'(SKID_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fifo_rd_en <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (can_issue) begin
                  state      <= ISSUE;
                  fifo_rd_en <= 1'b1;
               end
            end
            ISSUE: begin
               state      <= CAPTURE;
               fifo_rd_en <= 1'b0;
            end
            CAPTURE: begin
               if (can_issue) begin
                  state      <= ISSUE;
                  fifo_rd_en <= 1'b1;
               end else begin
                  state      <= IDLE;
                  fifo_rd_en <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               fifo_rd_en <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         words_out <= '0;
      else if (accept)
         words_out <= words_out + CNT_W'(1);
   end

   skid_buf2 #(.W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (capture),
      .push_data (fifo_dout),
      .pop       (accept),
      .head_data (m_data),
      .occupancy (occ)
   );

   assign m_valid = (occ != '0);
   assign busy    = (state != IDLE) || m_valid;

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side engine for the 32-bit synchronous FIFO. It issues `fifo_rd_en` pulses against the FIFO's registered `fifo_empty` flag and captures `fifo_dout` one cycle after each pop. It then presents the words on a valid/ready stream through a 2-entry skid buffer, so peripheral consumers (UART/SPI TX paths) never touch the FIFO handshake directly. It also keeps a running count of delivered words.

## Interface
- `DATA_W`, 32, data width; matches the FIFO word width.
- `CNT_W`, 16, width of the delivered-word counter.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when 0, no new pops are issued. In-flight capture and buffered output still complete.
- `fifo_empty` in 1: FIFO empty flag; registered and lagging the FIFO's internal count by one cycle.
- `fifo_dout` in DATA_W: FIFO read data; valid the cycle after a pop.
- `fifo_rd_en` out 1: pop request to the FIFO.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word when `m_valid && m_ready`.
- `m_data` out DATA_W: output word, head of the skid buffer.
- `words_out` out CNT_W: number of accepted output transfers; wraps modulo 2^CNT_W.
- `busy` out 1: high while a pop is in flight or the buffer is non-empty.

## Operation
- **FSM states:** IDLE, ISSUE, CAPTURE.
- **IDLE → ISSUE** when all of these hold:
  - `enable=1`
  - `fifo_empty=0`
  - buffer occupancy ≤ 1 (free slot guaranteed for the in-flight word).
- **ISSUE:** `fifo_rd_en=1` for exactly this one cycle. Always transitions to CAPTURE.
- **CAPTURE:** `fifo_rd_en=0`. `fifo_dout` is written into the buffer tail.
  - Goes to ISSUE if the IDLE→ISSUE condition holds this cycle; otherwise to IDLE.
- **Two-cycle minimum between pops.**
  - `fifo_rd_en` is never high on two consecutive cycles.
  - Reason: `fifo_empty` lags by one cycle, so a back-to-back pop after the last word would underflow the FIFO.
  - Sustained throughput is 1 word per 2 cycles.
- **Skid buffer:** 2 entries, FIFO-ordered.
  - `m_valid` = (occupancy ≠ 0).
  - `m_data` = head entry.
- **Simultaneous capture and accept:** head pops and tail pushes in the same cycle; occupancy unchanged.
  - This holds with occupancy 1 or 2.
  - With occupancy 0, the captured word becomes the head next cycle; there is no bypass.
- **Occupancy overflow:** impossible by the issue rule. Verification asserts occupancy ≤ 2.
- **`words_out`:** increments on every `m_valid && m_ready`; wraps 0xFFFF→0x0000.
- **`enable` deassertion:** blocks the IDLE/CAPTURE→ISSUE transition only. It never cancels an ISSUE or CAPTURE already underway.
- **`busy`** = (state ≠ IDLE) || `m_valid`.

## Timing
- **Reset values:**
  - state=IDLE
  - `fifo_rd_en=0`
  - `m_valid=0`
  - `m_data=0`
  - occupancy=0
  - `words_out=0`
  - `busy=0`
- **Reset mid-operation:** a word popped in ISSUE before `rst` is discarded, and buffered words are dropped. The FIFO and `fifo_drain` share `rst` and are reset together.
- **Latency:** `fifo_empty` falls at cycle t → ISSUE at t (combinational decision, registered `fifo_rd_en` out at t+1). Capture at t+2, `m_valid=1` at t+3.
  - `fifo_rd_en` is a registered output; the decision is made on the prior edge.
- **Stall:** `m_ready=0` for any duration holds `m_data`/`m_valid` stable. Pops stop once occupancy (including the in-flight word) reaches 2.
- **`m_data` change:** only on an accepted transfer, or when loading into an empty buffer.

## Structure
- Shared package `periph_pkg`:
  - `DATA_W` default constant
  - state enum {IDLE, ISSUE, CAPTURE}
  - skid depth constant `SKID_DEPTH=2`
- Sub-module `skid_buf2`, instanced once: 2-entry valid/ready buffer.
  - Ports: push, push_data, pop, head_data, occupancy.
- Top level contains the FSM, the issue-credit logic and `words_out`.

## Test plan
- **Basic drain:** preload 4 words 0xA0..0xA3, `m_ready=1`.
  - `fifo_rd_en` pulses every other cycle.
  - `m_data` sequence is A0,A1,A2,A3; `words_out=4`.
  - No pop once `fifo_empty=1`.
- **Last-word underflow guard:** FIFO holds 1 word.
  - Exactly one `fifo_rd_en` pulse; none on the next cycle while stale `fifo_empty=0`.
  - FIFO count stays ≥0.
- **Backpressure:** preload 6 words, `m_ready=0` for 20 cycles.
  - `m_valid=1` with `m_data` held at word0.
  - Exactly 2 pops total, occupancy 2.
  - Then `m_ready=1`: all 6 words arrive in order.
- **Simultaneous capture/accept:** occupancy 1, accept in the CAPTURE cycle.
  - Occupancy stays 1; order preserved.
- **Enable gating:** drop `enable` in ISSUE.
  - The in-flight word is still delivered; no further pops until `enable=1`.
- **Reset mid-flight:** assert `rst` in CAPTURE with 1 word buffered.
  - Next cycle `m_valid=0`, `words_out=0`, state IDLE.
- **Counter wrap:** force 65536 transfers → `words_out` returns to 0x0000.
